// File: rtl/dram_arbiter.sv
// dram_arbiter: round-robin two-port arbiter with bounded burst lock in front of single-port DRAM
module dram_arbiter #(
  parameter int DA_WIDTH = 11,
  parameter int DD_WIDTH = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                R0_REQ,
  input  logic                R0_LOCK,
  input  logic                R0_WE,
  input  logic [DA_WIDTH-1:0] R0_A,
  input  logic [DD_WIDTH-1:0] R0_DIN,
  output logic                R0_ACK,
  output logic                R0_RVALID,
  output logic [DD_WIDTH-1:0] R0_RDATA,
  input  logic                R1_REQ,
  input  logic                R1_LOCK,
  input  logic                R1_WE,
  input  logic [DA_WIDTH-1:0] R1_A,
  input  logic [DD_WIDTH-1:0] R1_DIN,
  output logic                R1_ACK,
  output logic                R1_RVALID,
  output logic [DD_WIDTH-1:0] R1_RDATA,
  output logic [DA_WIDTH-1:0] M_A,
  output logic [DD_WIDTH-1:0] M_DIN,
  output logic                M_EN,
  output logic                M_WE,
  input  logic [DD_WIDTH-1:0] M_DOUT
);
  localparam int HW = $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] HMAX = HW'(MAX_HOLD);

  logic          last_q, last_d, owner_q, owner_d, locked_q, locked_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [1:0]    rv_q, rv_d;
  logic [1:0]    req;
  logic          keep, g, gv, lk;

  // Grant selection, memory port muxing and next-state; a locked owner wins until the hold budget is spent against a waiting competitor
  always_comb begin
    req      = {R1_REQ, R0_REQ};
    keep     = locked_q && req[owner_q] && !(req[!owner_q] && hold_q == HMAX);
    g        = keep ? owner_q : (req == 2'b10) ? 1'b1 : (req == 2'b01) ? 1'b0 : !last_q;
    gv       = !RST && (|req);
    lk       = g ? R1_LOCK : R0_LOCK;
    R0_ACK   = gv && !g;
    R1_ACK   = gv && g;
    M_EN     = gv;
    M_WE     = gv && (g ? R1_WE : R0_WE);
    M_A      = gv ? (g ? R1_A : R0_A) : '0;
    M_DIN    = gv ? (g ? R1_DIN : R0_DIN) : '0;
    last_d   = gv ? g : last_q;
    owner_d  = gv ? g : owner_q;
    locked_d = gv && lk;
    hold_d   = !gv ? '0 : (g == owner_q && locked_q) ? ((hold_q == HMAX) ? hold_q : hold_q + HW'(1)) : HW'(1);
    rv_d     = (gv && !M_WE) ? (g ? 2'b10 : 2'b01) : 2'b00;
  end

  assign R0_RVALID = rv_q[0];
  assign R1_RVALID = rv_q[1];
  assign R0_RDATA  = M_DOUT;
  assign R1_RDATA  = M_DOUT;

  // Arbitration state; reset favours R0 on the first tie and drops any read in flight
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      last_q   <= 1'b1;
      owner_q  <= 1'b0;
      locked_q <= 1'b0;
      hold_q   <= '0;
      rv_q     <= 2'b00;
    end else begin
      last_q   <= last_d;
      owner_q  <= owner_d;
      locked_q <= locked_d;
      hold_q   <= hold_d;
      rv_q     <= rv_d;
    end
  end
endmodule

// File: tb/tb_dram_arbiter.sv
// tb_dram_arbiter: directed vector table plus reset corner sequence against a DRAM model
module tb_dram_arbiter;
  logic        clk = 0, rst = 1;
  logic        r0_req = 0, r0_lock = 0, r0_we = 0, r1_req = 0, r1_lock = 0, r1_we = 0;
  logic [10:0] r0_a = 0, r1_a = 0, m_a;
  logic [7:0]  r0_din = 0, r1_din = 0, m_din, m_dout, r0_rdata, r1_rdata;
  logic        r0_ack, r1_ack, r0_rv, r1_rv, m_en, m_we;
  logic [7:0]  mem [0:2047];
  int          checks = 0, errors = 0;

  typedef struct {
    logic [2:0]  c0;
    logic [10:0] a0;
    logic [7:0]  d0;
    logic [2:0]  c1;
    logic [10:0] a1;
    logic [7:0]  d1;
    logic [3:0]  ex;
    logic [7:0]  rd;
  } vec_t;

  vec_t tv [0:23];

  dram_arbiter dut (
    .CLK(clk), .RST(rst),
    .R0_REQ(r0_req), .R0_LOCK(r0_lock), .R0_WE(r0_we), .R0_A(r0_a), .R0_DIN(r0_din),
    .R0_ACK(r0_ack), .R0_RVALID(r0_rv), .R0_RDATA(r0_rdata),
    .R1_REQ(r1_req), .R1_LOCK(r1_lock), .R1_WE(r1_we), .R1_A(r1_a), .R1_DIN(r1_din),
    .R1_ACK(r1_ack), .R1_RVALID(r1_rv), .R1_RDATA(r1_rdata),
    .M_A(m_a), .M_DIN(m_din), .M_EN(m_en), .M_WE(m_we), .M_DOUT(m_dout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (m_en) begin
    if (m_we) mem[m_a] <= m_din;
    m_dout <= mem[m_a];
  end

  function automatic vec_t v(input logic [2:0] c0, input logic [10:0] a0, input logic [7:0] d0,
                             input logic [2:0] c1, input logic [10:0] a1, input logic [7:0] d1,
                             input logic [3:0] ex, input logic [7:0] rd);
    v = '{c0, a0, d0, c1, a1, d1, ex, rd};
  endfunction

  task automatic chk(input string nm, input int i, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %h expected %h", nm, i, act, exp);
    end
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = 8'h00;
    m_dout = 8'h00;
    // c = {req,lock,we}; ex = {ack0,ack1,rv0,rv1}
    tv[0]  = v(3'b100, 11'h005, 8'h00, 3'b000, 11'h000, 8'h00, 4'b1000, 8'h00);
    tv[1]  = v(3'b000, 11'h000, 8'h00, 3'b000, 11'h000, 8'h00, 4'b0010, 8'h00);
    tv[2]  = v(3'b000, 11'h000, 8'h00, 3'b101, 11'h7FF, 8'h5A, 4'b0100, 8'h00);
    tv[3]  = v(3'b100, 11'h7FF, 8'h00, 3'b000, 11'h000, 8'h00, 4'b1000, 8'h00);
    tv[4]  = v(3'b000, 11'h000, 8'h00, 3'b000, 11'h000, 8'h00, 4'b0010, 8'h5A);
    tv[5]  = v(3'b000, 11'h000, 8'h00, 3'b100, 11'h7FF, 8'h00, 4'b0100, 8'h00);
    tv[6]  = v(3'b100, 11'h7FF, 8'h00, 3'b100, 11'h005, 8'h00, 4'b1001, 8'h5A);
    tv[7]  = v(3'b100, 11'h7FF, 8'h00, 3'b100, 11'h005, 8'h00, 4'b0110, 8'h5A);
    tv[8]  = v(3'b100, 11'h7FF, 8'h00, 3'b100, 11'h005, 8'h00, 4'b1001, 8'h00);
    tv[9]  = v(3'b100, 11'h7FF, 8'h00, 3'b100, 11'h005, 8'h00, 4'b0110, 8'h5A);
    tv[10] = v(3'b100, 11'h7FF, 8'h00, 3'b100, 11'h005, 8'h00, 4'b1001, 8'h00);
    tv[11] = v(3'b100, 11'h7FF, 8'h00, 3'b100, 11'h005, 8'h00, 4'b0110, 8'h5A);
    tv[12] = v(3'b000, 11'h000, 8'h00, 3'b000, 11'h000, 8'h00, 4'b0001, 8'h00);
    tv[13] = v(3'b110, 11'h005, 8'h00, 3'b000, 11'h000, 8'h00, 4'b1000, 8'h00);
    tv[14] = v(3'b110, 11'h005, 8'h00, 3'b100, 11'h7FF, 8'h00, 4'b1010, 8'h00);
    tv[15] = v(3'b110, 11'h005, 8'h00, 3'b100, 11'h7FF, 8'h00, 4'b1010, 8'h00);
    tv[16] = v(3'b110, 11'h005, 8'h00, 3'b100, 11'h7FF, 8'h00, 4'b1010, 8'h00);
    tv[17] = v(3'b110, 11'h005, 8'h00, 3'b100, 11'h7FF, 8'h00, 4'b0110, 8'h00);
    tv[18] = v(3'b110, 11'h005, 8'h00, 3'b000, 11'h000, 8'h00, 4'b1001, 8'h5A);
    tv[19] = v(3'b000, 11'h000, 8'h00, 3'b110, 11'h7FF, 8'h00, 4'b0110, 8'h00);
    tv[20] = v(3'b100, 11'h005, 8'h00, 3'b110, 11'h7FF, 8'h00, 4'b0101, 8'h5A);
    tv[21] = v(3'b100, 11'h005, 8'h00, 3'b100, 11'h7FF, 8'h00, 4'b0101, 8'h5A);
    tv[22] = v(3'b100, 11'h005, 8'h00, 3'b100, 11'h7FF, 8'h00, 4'b1001, 8'h5A);
    tv[23] = v(3'b000, 11'h000, 8'h00, 3'b000, 11'h000, 8'h00, 4'b0010, 8'h00);
    r0_req = 1; r1_req = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ack0", -1, 8'(r0_ack), 8'h0);
    chk("rst_ack1", -1, 8'(r1_ack), 8'h0);
    chk("rst_men", -1, 8'(m_en), 8'h0);
    chk("rst_rv", -1, 8'({r0_rv, r1_rv}), 8'h0);
    r0_req = 0; r1_req = 0;
    @(negedge clk) rst = 0;
    @(posedge clk);
    for (int i = 0; i < 24; i++) begin
      #1;
      {r0_req, r0_lock, r0_we} = tv[i].c0; r0_a = tv[i].a0; r0_din = tv[i].d0;
      {r1_req, r1_lock, r1_we} = tv[i].c1; r1_a = tv[i].a1; r1_din = tv[i].d1;
      @(negedge clk);
      chk("ack0", i, 8'(r0_ack), 8'(tv[i].ex[3]));
      chk("ack1", i, 8'(r1_ack), 8'(tv[i].ex[2]));
      chk("rvalid0", i, 8'(r0_rv), 8'(tv[i].ex[1]));
      chk("rvalid1", i, 8'(r1_rv), 8'(tv[i].ex[0]));
      chk("m_en", i, 8'(m_en), 8'(tv[i].ex[3] | tv[i].ex[2]));
      if (tv[i].ex[1]) chk("rdata0", i, r0_rdata, tv[i].rd);
      if (tv[i].ex[0]) chk("rdata1", i, r1_rdata, tv[i].rd);
      if (!(tv[i].ex[3] | tv[i].ex[2])) chk("m_a_idle", i, 8'(m_a), 8'h00);
      @(posedge clk);
    end
    #1;
    r0_req = 1; r0_lock = 0; r0_we = 0; r0_a = 11'h7FF; r1_req = 0; r1_lock = 0; r1_we = 0;
    @(negedge clk);
    chk("pre_rst_ack0", 100, 8'(r0_ack), 8'h1);
    @(posedge clk);
    #1 rst = 1;
    #1;
    chk("mid_rst_rv0", 101, 8'(r0_rv), 8'h0);
    chk("mid_rst_ack0", 101, 8'(r0_ack), 8'h0);
    chk("mid_rst_men", 101, 8'(m_en), 8'h0);
    r1_req = 1;
    @(negedge clk) rst = 0;
    #1;
    chk("post_rst_ack0", 102, 8'(r0_ack), 8'h1);
    chk("post_rst_ack1", 102, 8'(r1_ack), 8'h0);
    @(posedge clk);
    #1 r0_req = 0; r1_req = 0;
    @(negedge clk);
    chk("post_rst_rv0", 103, 8'(r0_rv), 8'h1);
    chk("post_rst_rdata0", 103, r0_rdata, 8'h5A);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
